// File: rtl/bin_to_bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Provides the digit type, FSM state encoding, MAX_DEC helper and the BCD nine constant.
package bin_to_bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_e;

  localparam bcd_digit_t BCD_NINE = 4'd9;

  function automatic longint unsigned max_dec(input int digits);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Ports: d = scratch digit before the shift, q = corrected digit.
module bcd_digit_adj
  import bin_to_bcd_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);

  assign q = (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter, one operand bit per clock, with handshake.
// Ports: clk, reset_n (async low), in_valid/in_ready/bin_in in, out_valid/bcd_out/overflow out.
// Build option: define BIN_TO_BCD_SATURATE_EN to clamp overflowed results to all nines.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam longint unsigned MAX_DEC = max_dec(DIGITS);
  // Overflow only exists when the input range exceeds MAX_DEC.
  localparam bit OVF_EN =
    (BIN_W >= 63) || (((64'd1 << BIN_W) - 64'd1) > MAX_DEC);
  localparam logic [BIN_W:0] MAX_CMP =
    OVF_EN ? (BIN_W+1)'(MAX_DEC) : {(BIN_W+1){1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  bcd_state_e       state_q;
  bcd_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [BIN_W-1:0] sh_q;
  logic [SW-1:0]    scr_q;
  logic [SW-1:0]    scr_adj;
  logic [SW-1:0]    done_bcd;
  logic             ovf_q;
  logic             accept;
  logic             last;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;
  assign last     = (cnt_q == CNT_LAST);

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (scr_q[4*g +: 4]),
      .q (scr_adj[4*g +: 4])
    );
  end

`ifdef BIN_TO_BCD_SATURATE_EN
  assign done_bcd = ovf_q ? {DIGITS{BCD_NINE}} : scr_q;
`else
  assign done_bcd = scr_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      sh_q      <= '0;
      scr_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sh_q  <= bin_in;
            scr_q <= '0;
            cnt_q <= '0;
            ovf_q <= OVF_EN && ({1'b0, bin_in} > MAX_CMP);
          end
        end
        SHIFT: begin
          // Top-digit carry falls off: result wraps mod 10**DIGITS.
          scr_q <= SW'({scr_adj, sh_q[BIN_W-1]});
          sh_q  <= sh_q << 1;
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          out_valid <= 1'b1;
          bcd_out   <= done_bcd;
          overflow  <= ovf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: 3-digit and 2-digit instances, 8-bit inputs.
// Drivers push expected results; negedge monitors pop and compare on out_valid.
module tb_bin_to_bcd_seq;

`ifdef BIN_TO_BCD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid3, in_ready3, out_valid3, overflow3;
  logic [7:0]  bin_in3;
  logic [11:0] bcd_out3;
  logic        in_valid2, in_ready2, out_valid2, overflow2;
  logic [7:0]  bin_in2;
  logic [7:0]  bcd_out2;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q3[$];
  exp_t q2[$];
  logic ov3_prev = 1'b0;
  logic ov2_prev = 1'b0;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .bin_in(bin_in3),
    .out_valid(out_valid3), .bcd_out(bcd_out3), .overflow(overflow3)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .bin_in(bin_in2),
    .out_valid(out_valid2), .bcd_out(bcd_out2), .overflow(overflow2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] dec3(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid3) begin
        chk("strobe3_single", 32'(ov3_prev), 0);
        for (int k = 0; k < 3; k++)
          chk("digit3_le9", 32'(bcd_out3[4*k +: 4] > 4'd9), 0);
        if (q3.size() == 0) chk("unexpected_out3", 1, 0);
        else begin
          exp_t e;
          e = q3.pop_front();
          chk("bcd3", 32'(bcd_out3), 32'(e.bcd));
          chk("ovf3", 32'(overflow3), 32'(e.ovf));
          chk("latency3", cyc, e.due);
        end
      end
      if (out_valid2) begin
        chk("strobe2_single", 32'(ov2_prev), 0);
        for (int k = 0; k < 2; k++)
          chk("digit2_le9", 32'(bcd_out2[4*k +: 4] > 4'd9), 0);
        if (q2.size() == 0) chk("unexpected_out2", 1, 0);
        else begin
          exp_t e;
          e = q2.pop_front();
          chk("bcd2", 32'(bcd_out2), 32'(e.bcd[7:0]));
          chk("ovf2", 32'(overflow2), 32'(e.ovf));
          chk("latency2", cyc, e.due);
        end
      end
    end
    ov3_prev = out_valid3;
    ov2_prev = out_valid2;
  end

  task automatic send3(input logic [7:0] v, input logic [11:0] eb,
                       input logic eo, input bit expect_out);
    int n = 0;
    @(negedge clk);
    while (!in_ready3 && n < 100) begin @(negedge clk); n++; end
    if (!in_ready3) chk("ready3_timeout", 0, 1);
    in_valid3 = 1'b1;
    bin_in3   = v;
    if (expect_out) q3.push_back('{eb, eo, cyc + 10});
    @(negedge clk);
    in_valid3 = 1'b0;
    bin_in3   = 8'hxx;
  endtask

  task automatic send2(input logic [7:0] v, input logic [7:0] eb,
                       input logic eo);
    int n = 0;
    @(negedge clk);
    while (!in_ready2 && n < 100) begin @(negedge clk); n++; end
    if (!in_ready2) chk("ready2_timeout", 0, 1);
    in_valid2 = 1'b1;
    bin_in2   = v;
    q2.push_back('{{4'd0, eb}, eo, cyc + 10});
    @(negedge clk);
    in_valid2 = 1'b0;
    bin_in2   = 8'hxx;
  endtask

  task automatic drain();
    int n = 0;
    while ((q3.size() + q2.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(q3.size() + q2.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid3 = 1'b0;
    in_valid2 = 1'b0;
    bin_in3   = '0;
    bin_in2   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready3", 32'(in_ready3), 1);
    chk("rst_valid3", 32'(out_valid3), 0);
    chk("rst_bcd3", 32'(bcd_out3), 0);
    chk("rst_ovf3", 32'(overflow3), 0);
    chk("rst_ready2", 32'(in_ready2), 1);
    chk("rst_bcd2", 32'(bcd_out2), 0);
    reset_n = 1'b1;

    send3(8'd255, 12'h255, 1'b0, 1'b1);
    drain();
    send3(8'd0,   12'h000, 1'b0, 1'b1);
    send3(8'd19,  12'h019, 1'b0, 1'b1);
    send3(8'd128, 12'h128, 1'b0, 1'b1);
    send3(8'd99,  12'h099, 1'b0, 1'b1);
    drain();
    repeat (5) @(negedge clk);
    chk("hold_bcd3", 32'(bcd_out3), 32'h099);
    chk("hold_valid3", 32'(out_valid3), 0);

    send2(8'd255, SAT ? 8'h99 : 8'h55, 1'b1);
    send2(8'd99,  8'h99, 1'b0);
    send2(8'd100, SAT ? 8'h99 : 8'h00, 1'b1);
    send2(8'd0,   8'h00, 1'b0);
    send2(8'd57,  8'h57, 1'b0);
    send2(8'd123, SAT ? 8'h99 : 8'h23, 1'b1);
    drain();

    begin
      int since = 100;
      for (int i = 0; i < 35; i++) begin
        int v;
        logic rdy;
        @(negedge clk);
        v   = (i * 37 + 11) % 256;
        rdy = (since >= 10);
        chk("hold_in_ready3", 32'(in_ready3), 32'(rdy));
        in_valid3 = 1'b1;
        bin_in3   = 8'(v);
        if (rdy) begin
          q3.push_back('{dec3(v), 1'b0, cyc + 10});
          since = 0;
        end
        since++;
      end
      @(negedge clk);
      in_valid3 = 1'b0;
    end
    drain();

    send3(8'd77, 12'h077, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_bcd3", 32'(bcd_out3), 0);
    chk("abort_ready3", 32'(in_ready3), 1);
    chk("abort_valid3", 32'(out_valid3), 0);
    chk("abort_ovf3", 32'(overflow3), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_quiet_bcd3", 32'(bcd_out3), 0);
    send3(8'd42, 12'h042, 1'b0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
